// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, blank digit-enable pattern and capture FSM states shared by the 7-segment blocks
package seg7_pkg;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [3:0] AN_BLANK = 4'hF;
  typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low segment code to decimal digit, flagging any code the driver never emits
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       bad
);
  always_comb begin
    digit = 4'd0;
    bad   = 1'b0;
    case (seg)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/synchronizer.sv
// synchronizer: 2-flop input synchronizer with selectable reset value
module synchronizer #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers the number shown on a multiplexed 4-digit 7-segment display
// by latching settled digits into a frame and converting it from BCD to binary.
module seven_seg_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 512,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [13:0] value,
  output logic [15:0] digits,
  output logic        value_valid,
  output logic        frame_err,
  output logic        no_signal
);
  logic [3:0] an_s, an_p, mask, mask_or, lbit, slot_bad, slot_bad_n, snap_bad;
  logic [6:0] seg_s, seg_p;
  logic [3:0][3:0] slot_d, slot_d_n, snap_d;
  logic [CNT_W-1:0] settle, to_cnt;
  logic [13:0] acc, acc_n;
  logic [3:0] dec_d;
  logic [1:0] k, idx;
  logic dec_bad, legal, stable, latch, expire, start, finish;
  state_t state, state_n;
  synchronizer #(.WIDTH(4), .RST_VAL(AN_BLANK)) u_sync_an (.clk(clk), .reset(reset), .d(an), .q(an_s));
  synchronizer #(.WIDTH(7), .RST_VAL(7'h7F)) u_sync_seg (.clk(clk), .reset(reset), .d(seg), .q(seg_s));
  seg7_decode u_dec (.seg(seg_s), .digit(dec_d), .bad(dec_bad));
  assign legal   = an_s inside {4'hE, 4'hD, 4'hB, 4'h7};
  assign stable  = an_s == an_p && seg_s == seg_p;
  // settle saturates one past the latch point so each display phase latches once
  assign latch   = legal && stable && settle == CNT_W'(SETTLE_CYCLES - 1);
  assign k       = an_s == 4'hE ? 2'd0 : an_s == 4'hD ? 2'd1 : an_s == 4'hB ? 2'd2 : 2'd3;
  assign lbit    = latch ? 4'b0001 << k : 4'b0000;
  assign mask_or = mask | lbit;
  assign expire  = !latch && to_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign start   = state == COLLECT && mask_or == 4'hF;
  assign finish  = state == CONVERT && idx == 2'd3;
  assign acc_n   = (acc << 3) + (acc << 1) + {10'd0, snap_d[~idx]};
  always_comb begin
    slot_d_n   = slot_d;
    slot_bad_n = slot_bad;
    for (int i = 0; i < 4; i++) begin
      slot_d_n[i]   = lbit[i] ? dec_d : slot_d[i];
      slot_bad_n[i] = lbit[i] ? dec_bad : slot_bad[i];
    end
  end
  always_comb begin
    state_n = state == COLLECT ? (start ? CONVERT : COLLECT) :
              state == CONVERT ? (idx == 2'd3 ? DONE : CONVERT) : COLLECT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p        <= AN_BLANK;
      seg_p       <= 7'h7F;
      settle      <= '0;
      to_cnt      <= '0;
      mask        <= '0;
      slot_d      <= '0;
      slot_bad    <= '0;
      snap_d      <= '0;
      snap_bad    <= '0;
      acc         <= '0;
      idx         <= '0;
      value       <= '0;
      digits      <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
      no_signal   <= 1'b1;
    end else begin
      an_p        <= an_s;
      seg_p       <= seg_s;
      settle      <= !(legal && stable) ? '0 : settle == CNT_W'(SETTLE_CYCLES) ? settle : settle + 1'b1;
      to_cnt      <= latch ? '0 : expire ? to_cnt : to_cnt + 1'b1;
      no_signal   <= latch ? 1'b0 : expire ? 1'b1 : no_signal;
      mask        <= start || expire ? 4'h0 : mask_or;
      slot_d      <= slot_d_n;
      slot_bad    <= slot_bad_n;
      value_valid <= finish && ~|snap_bad;
      frame_err   <= finish && |snap_bad;
      if (start) begin
        snap_d   <= slot_d_n;
        snap_bad <= slot_bad_n;
        acc      <= '0;
        idx      <= '0;
      end
      if (state == CONVERT) begin
        acc <= acc_n;
        idx <= idx + 2'd1;
      end
      if (finish && ~|snap_bad) begin
        value  <= acc_n;
        digits <= snap_d;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed scans of the display lines with hand-computed expectations,
// run with shortened settle/timeout constants.
module tb_seven_seg_capture;
  import seg7_pkg::*;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 4096;
  localparam int HOLD    = 64;
  localparam int BLANK   = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] an = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic [13:0] value;
  logic [15:0] digits;
  logic value_valid, frame_err, no_signal;
  int cyc = 0, vv_n = 0, fe_n = 0, vv_cyc = 0;
  int n_vec = 0, n_err = 0;
  seven_seg_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(13)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .value(value), .digits(digits),
    .value_valid(value_valid), .frame_err(frame_err), .no_signal(no_signal)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (value_valid) begin
      vv_n   <= vv_n + 1;
      vv_cyc <= cyc;
    end
    if (frame_err) fe_n <= fe_n + 1;
  end
  task automatic scan_digit(input logic [3:0] a, input logic [6:0] s, output int c0);
    @(negedge clk);
    c0 = cyc;
    an = a;
    seg = s;
    repeat (HOLD) @(negedge clk);
    an = 4'hF;
    seg = 7'h7F;
    repeat (BLANK - 1) @(negedge clk);
  endtask
  task automatic scan_frame(input logic [6:0] s3, s2, s1, s0, output int c3);
    int c;
    scan_digit(4'hE, s0, c);
    scan_digit(4'hD, s1, c);
    scan_digit(4'hB, s2, c);
    scan_digit(4'h7, s3, c3);
  endtask
  task automatic test_reset;
    repeat (50) @(negedge clk);
    n_vec++; if (no_signal !== 1'b1) begin n_err++; $display("FAIL reset_no_signal got %b want 1", no_signal); end
    n_vec++; if (value !== 14'd0) begin n_err++; $display("FAIL reset_value got %0d want 0", value); end
    n_vec++; if (digits !== 16'h0) begin n_err++; $display("FAIL reset_digits got %h want 0000", digits); end
    n_vec++; if (vv_n + fe_n !== 0) begin n_err++; $display("FAIL reset_pulses got %0d want 0", vv_n + fe_n); end
  endtask
  task automatic test_good_frame;
    int v0, f0, c3;
    v0 = vv_n; f0 = fe_n;
    scan_frame(SEG_1, SEG_2, SEG_3, SEG_4, c3);
    n_vec++; if (vv_n - v0 !== 1) begin n_err++; $display("FAIL good_vv_count got %0d want 1", vv_n - v0); end
    n_vec++; if (fe_n - f0 !== 0) begin n_err++; $display("FAIL good_fe_count got %0d want 0", fe_n - f0); end
    n_vec++; if (vv_cyc - c3 !== SETTLE + 7) begin n_err++; $display("FAIL good_latency got %0d want %0d", vv_cyc - c3, SETTLE + 7); end
    n_vec++; if (value !== 14'd1234) begin n_err++; $display("FAIL good_value got %0d want 1234", value); end
    n_vec++; if (digits !== 16'h1234) begin n_err++; $display("FAIL good_digits got %h want 1234", digits); end
    n_vec++; if (no_signal !== 1'b0) begin n_err++; $display("FAIL good_no_signal got %b want 0", no_signal); end
  endtask
  task automatic test_bad_digit;
    int v0, f0, c3;
    v0 = vv_n; f0 = fe_n;
    scan_frame(SEG_1, SEG_DASH, SEG_3, SEG_4, c3);
    n_vec++; if (fe_n - f0 !== 1) begin n_err++; $display("FAIL bad_fe_count got %0d want 1", fe_n - f0); end
    n_vec++; if (vv_n - v0 !== 0) begin n_err++; $display("FAIL bad_vv_count got %0d want 0", vv_n - v0); end
    n_vec++; if (value !== 14'd1234) begin n_err++; $display("FAIL bad_value_hold got %0d want 1234", value); end
    n_vec++; if (digits !== 16'h1234) begin n_err++; $display("FAIL bad_digits_hold got %h want 1234", digits); end
    v0 = vv_n;
    scan_frame(SEG_9, SEG_9, SEG_9, SEG_9, c3);
    n_vec++; if (vv_n - v0 !== 1) begin n_err++; $display("FAIL max_vv_count got %0d want 1", vv_n - v0); end
    n_vec++; if (value !== 14'd9999) begin n_err++; $display("FAIL max_value got %0d want 9999", value); end
    n_vec++; if (digits !== 16'h9999) begin n_err++; $display("FAIL max_digits got %h want 9999", digits); end
  endtask
  task automatic test_glitch;
    int v0, f0;
    v0 = vv_n; f0 = fe_n;
    @(negedge clk);
    an = 4'b1100;
    seg = SEG_5;
    repeat (500) @(negedge clk);
    an = 4'hE;
    for (int i = 0; i < 50; i++) begin
      seg = i[0] ? SEG_6 : SEG_8;
      repeat (10) @(negedge clk);
    end
    an = 4'hF;
    seg = 7'h7F;
    repeat (20) @(negedge clk);
    n_vec++; if (vv_n - v0 + fe_n - f0 !== 0) begin n_err++; $display("FAIL glitch_pulses got %0d want 0", vv_n - v0 + fe_n - f0); end
    n_vec++; if (dut.mask !== 4'b0000) begin n_err++; $display("FAIL glitch_mask got %b want 0000", dut.mask); end
    n_vec++; if (value !== 14'd9999) begin n_err++; $display("FAIL glitch_value got %0d want 9999", value); end
  endtask
  task automatic test_timeout;
    int c0, c3;
    scan_digit(4'hE, SEG_0, c0);
    n_vec++; if (dut.mask !== 4'b0001) begin n_err++; $display("FAIL to_mask_before got %b want 0001", dut.mask); end
    while (cyc != c0 + SETTLE + 3 + TIMEOUT - 1) @(negedge clk);
    n_vec++; if (no_signal !== 1'b0) begin n_err++; $display("FAIL to_pre_expiry got %b want 0", no_signal); end
    @(negedge clk);
    n_vec++; if (no_signal !== 1'b1) begin n_err++; $display("FAIL to_expiry got %b want 1", no_signal); end
    n_vec++; if (dut.mask !== 4'b0000) begin n_err++; $display("FAIL to_mask_cleared got %b want 0000", dut.mask); end
    @(negedge clk);
    c0 = cyc;
    an = 4'hE;
    seg = SEG_7;
    while (cyc != c0 + SETTLE + 2) @(negedge clk);
    n_vec++; if (no_signal !== 1'b1) begin n_err++; $display("FAIL resume_before_latch got %b want 1", no_signal); end
    @(negedge clk);
    n_vec++; if (no_signal !== 1'b0) begin n_err++; $display("FAIL resume_after_latch got %b want 0", no_signal); end
    repeat (HOLD - SETTLE - 3) @(negedge clk);
    an = 4'hF;
    seg = 7'h7F;
    repeat (BLANK - 1) @(negedge clk);
    scan_digit(4'hD, SEG_0, c0);
    scan_digit(4'hB, SEG_0, c0);
    scan_digit(4'h7, SEG_0, c3);
    n_vec++; if (value !== 14'd7) begin n_err++; $display("FAIL resume_value got %0d want 7", value); end
    n_vec++; if (digits !== 16'h0007) begin n_err++; $display("FAIL resume_digits got %h want 0007", digits); end
  endtask
  task automatic test_reset_mid_convert;
    int v0, f0, c0, c;
    v0 = vv_n; f0 = fe_n;
    scan_digit(4'hE, SEG_8, c);
    scan_digit(4'hD, SEG_7, c);
    scan_digit(4'hB, SEG_6, c);
    @(negedge clk);
    c0 = cyc;
    an = 4'h7;
    seg = SEG_5;
    while (cyc != c0 + SETTLE + 4) @(negedge clk);
    n_vec++; if (dut.state !== CONVERT) begin n_err++; $display("FAIL rst_in_convert got %0d want %0d", dut.state, CONVERT); end
    reset = 1'b1;
    an = 4'hF;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    n_vec++; if (vv_n - v0 + fe_n - f0 !== 0) begin n_err++; $display("FAIL rst_pulses got %0d want 0", vv_n - v0 + fe_n - f0); end
    n_vec++; if (value !== 14'd0) begin n_err++; $display("FAIL rst_value got %0d want 0", value); end
    n_vec++; if (digits !== 16'h0) begin n_err++; $display("FAIL rst_digits got %h want 0000", digits); end
    n_vec++; if (dut.mask !== 4'b0000) begin n_err++; $display("FAIL rst_mask got %b want 0000", dut.mask); end
    n_vec++; if (no_signal !== 1'b1) begin n_err++; $display("FAIL rst_no_signal got %b want 1", no_signal); end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_good_frame;
    test_bad_digit;
    test_glitch;
    test_timeout;
    test_reset_mid_convert;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
